// File: rtl/uart_pkg.sv
// uart_pkg: shared UART bit timing, FSM state encoding and frame levels (UART_TX_PARITY_EN adds the parity state).
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 76;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam logic BIT_START  = 1'b0;
  localparam logic BIT_STOP   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake between a producer (master) and the transmitter (slave).
interface uart_tx_if;
  logic [7:0] in__data;
  logic       in__valid;
  logic       in__ready;
  modport master(output in__data, output in__valid, input in__ready);
  modport slave(input in__data, input in__valid, output in__ready);
endinterface

// File: rtl/uart_baud_ctr.sv
// uart_baud_ctr: per-bit clock counter with clear and a bit_done strobe on the last cycle of each bit.
module uart_baud_ctr #(
  parameter int CLKS_PER_BIT = 76
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_done
);
  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] r_cnt;
  assign o_bit_done = i_en && (r_cnt == W'(CLKS_PER_BIT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr || o_bit_done) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter behind a valid/ready byte handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       out__tx
);
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = ST_PARITY;
  logic r_par;
`else
  localparam state_t AFTER_DATA = ST_STOP;
`endif
  state_t     r_state, w_next;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic       r_ready, r_tx, w_accept, w_bit_done, w_level;
  assign w_accept      = bus.in__valid && r_ready;
  assign bus.in__ready = r_ready;
  assign out__tx       = r_tx;
  uart_baud_ctr #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == ST_IDLE),
    .i_en      (r_state != ST_IDLE),
    .o_bit_done(w_bit_done)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = w_accept ? ST_START : ST_IDLE;
      ST_START:  w_next = w_bit_done ? ST_DATA : ST_START;
      ST_DATA:   w_next = (w_bit_done && r_idx == 3'd7) ? AFTER_DATA : ST_DATA;
      ST_PARITY: w_next = w_bit_done ? ST_STOP : ST_PARITY;
      ST_STOP:   w_next = w_bit_done ? ST_IDLE : ST_STOP;
      default:   w_next = ST_IDLE;
    endcase
  end
  // line level is registered, so each bit appears on out__tx one cycle after its state begins
  always_comb begin
    w_level = (r_state == ST_START) ? BIT_START :
              (r_state == ST_DATA)  ? r_shift[0] :
              (r_state == ST_STOP)  ? BIT_STOP : IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    if (r_state == ST_PARITY) w_level = r_par;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_tx    <= IDLE_LEVEL;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      r_tx    <= w_level;
      r_shift <= w_accept ? bus.in__data :
                 (r_state == ST_DATA && w_bit_done) ? r_shift >> 1 : r_shift;
      r_idx   <= (r_state != ST_DATA) ? 3'd0 : w_bit_done ? r_idx + 3'd1 : r_idx;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) r_par <= 1'b0;
    else if (w_accept) r_par <= even_parity(bus.in__data);
`endif
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and hand-sequenced checks of uart_tx with a frame scoreboard.
module tb_uart_tx;
  localparam int CPB = 76;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * CPB;
  typedef struct {
    logic [7:0] d;
    logic [9:0] fr;
    logic       par;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic out_tx;
  uart_tx_if bus();
  uart_tx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus), .out__tx(out_tx));
  always #5 clk = ~clk;
  int cyc = 0, acc_cyc = 0, acc_n = 0, n_pass = 0, n_chk = 0, last_fall = 0;
  logic [10:0] sb[$];
  vec_t tbl[8];
  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.in__valid === 1'b1 && bus.in__ready === 1'b1) begin
      acc_n++;
      acc_cyc = cyc;
    end
  end
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  function automatic logic [10:0] mk(vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.par, v.fr[8:0]};
`else
    return {1'b0, v.fr};
`endif
  endfunction
  task automatic send(vec_t v);
    int t, n0;
    n0 = acc_n;
    bus.in__data  = v.d;
    bus.in__valid = 1'b1;
    sb.push_back(mk(v));
    t = 0;
    while (acc_n == n0 && t < 3000) begin @(negedge clk); t++; end
    if (acc_n == n0) chk("accept_timeout", 0, 1);
    bus.in__valid = 1'b0;
  endtask
  task automatic rx_frame(string nm);
    int t;
    logic [10:0] got;
    got = '0;
    t = 0;
    while (out_tx !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
    if (out_tx !== 1'b0) begin chk({nm, "_start_timeout"}, 0, 1); return; end
    chk({nm, "_start_lat"}, cyc - acc_cyc, 1);
    last_fall = cyc;
    for (int k = 0; k < NB; k++) begin
      while (cyc < last_fall + CPB * k + CPB / 2) @(negedge clk);
      got[k] = out_tx;
    end
    if (sb.size() == 0) chk({nm, "_sb_empty"}, 0, 1);
    else chk({nm, "_frame"}, int'(got), int'(sb.pop_front()));
    t = 0;
    while (bus.in__ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    chk({nm, "_ready_lat"}, cyc - acc_cyc, FR);
  endtask
  initial begin
    int n0, f0, f;
    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[1] = '{8'h07, 10'b1000001110, 1'b1};
    tbl[2] = '{8'h03, 10'b1000000110, 1'b0};
    tbl[3] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[4] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[5] = '{8'h3C, 10'b1001111000, 1'b0};
    tbl[6] = '{8'h55, 10'b1010101010, 1'b0};
    tbl[7] = '{8'h81, 10'b1100000010, 1'b0};
    bus.in__valid = 1'b0;
    bus.in__data  = 8'h00;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", int'(out_tx), 1);
    chk("rst_ready", int'(bus.in__ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_ready_before_edge", int'(bus.in__ready), 0);
    @(negedge clk);
    chk("rel_ready_after_edge", int'(bus.in__ready), 1);
    for (int i = 0; i < 3; i++) begin
      send(tbl[i]);
      rx_frame($sformatf("tbl%0d", i));
    end
    n0 = acc_n;
    fork
      begin
        int t;
        bus.in__data  = tbl[3].d;
        bus.in__valid = 1'b1;
        sb.push_back(mk(tbl[3]));
        t = 0;
        while (acc_n < n0 + 1 && t < 2000) begin @(negedge clk); t++; end
        bus.in__data = tbl[4].d;
        sb.push_back(mk(tbl[4]));
        t = 0;
        while (acc_n < n0 + 2 && t < 2000) begin @(negedge clk); t++; end
        bus.in__valid = 1'b0;
      end
      begin
        rx_frame("b2b0");
        f0 = last_fall;
        @(negedge clk);
        chk("b2b_idle_line", int'(out_tx), 1);
        rx_frame("b2b1");
        chk("b2b_spacing", last_fall - f0, FR + 1);
      end
    join
    chk("b2b_accepts", acc_n - n0, 2);
    chk("b2b_sb_left", sb.size(), 0);
    n0 = acc_n;
    send(tbl[5]);
    fork
      rx_frame("stab");
      begin
        for (int i = 0; i < 40; i++) begin
          bus.in__data  = 8'hFF;
          bus.in__valid = ~bus.in__valid;
          repeat (15) @(negedge clk);
        end
        bus.in__valid = 1'b0;
      end
    join
    chk("stab_accepts", acc_n - n0, 1);
    chk("stab_sb_left", sb.size(), 0);
    send(tbl[6]);
    f = 0;
    while (out_tx !== 1'b0 && f < 4000) begin @(negedge clk); f++; end
    f = cyc;
    while (cyc < f + 4 * CPB + CPB / 2) @(negedge clk);
    chk("pre_rst_line", int'(out_tx), 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", int'(out_tx), 1);
    chk("mid_rst_ready", int'(bus.in__ready), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rel_ready_before_edge", int'(bus.in__ready), 0);
    @(negedge clk);
    chk("mid_rel_ready_after_edge", int'(bus.in__ready), 1);
    repeat (5) @(negedge clk);
    chk("mid_rel_idle_line", int'(out_tx), 1);
    send(tbl[7]);
    rx_frame("post_rst");
    chk("final_sb_left", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
